// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RISC-V control unit: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, with a timed memory handshake and a sticky fault state.
//
// state       | meaning
// FETCH   (0) | read instruction at PC, PC <= PC+4 on ready
// DECODE  (1) | classify, branch/jump target into ALUOut
// EXEC    (2) | R/I ALU operation
// ALUWB   (3) | write ALUOut to rd
// MEMADDR (4) | load/store address = rs1 + imm
// MEMRD   (5) | data read at ALUOut
// MEMWB   (6) | write MDR to rd
// MEMWR   (7) | data write at ALUOut
// BRANCH  (8) | compare rs1-rs2, conditional PC update
// JUMP    (9) | link write and PC update
// FAULT  (15) | illegal instruction or memory timeout, held until reset
module riscv_multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int ALU_CTRL_W  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic [1:0]            mod,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  PCWrite,
   output logic                  IorD,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  IRWrite,
   output logic                  RegWrite,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            PCSource,
   output logic [1:0]            MemToReg,
   output logic [ALU_CTRL_W-1:0] ALUcontrol,
   output logic [2:0]            InstType,
   output logic [3:0]            state,
   output logic                  fault
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC    = 4'd2,
      S_ALUWB   = 4'd3,
      S_MEMADDR = 4'd4,
      S_MEMRD   = 4'd5,
      S_MEMWB   = 4'd6,
      S_MEMWR   = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_FAULT   = 4'd15
   } state_t;

   localparam logic [2:0] T_ILL   = 3'b000;
   localparam logic [2:0] T_I     = 3'b001;
   localparam logic [2:0] T_LOAD  = 3'b010;
   localparam logic [2:0] T_STORE = 3'b011;
   localparam logic [2:0] T_BR    = 3'b100;
   localparam logic [2:0] T_JAL   = 3'b101;
   localparam logic [2:0] T_JALR  = 3'b110;
   localparam logic [2:0] T_R     = 3'b111;

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic [4:0] alu_op;
   logic       mem_timeout;

   assign mem_timeout = (wait_q == 8'(MEM_TIMEOUT));

   always_comb begin
      case (opcode)
         7'b0110011: InstType = T_R;
         7'b0010011: InstType = T_I;
         7'b0000011: InstType = T_LOAD;
         7'b0100011: InstType = T_STORE;
         7'b1100011: InstType = T_BR;
         7'b1101111: InstType = T_JAL;
         7'b1100111: InstType = T_JALR;
         default:    InstType = T_ILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 2'd0;
      ALUSrcB  = 2'd0;
      PCSource = 2'd0;
      MemToReg = 2'd0;
      alu_op   = 5'b00000;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'd1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               wait_d  = '0;
               state_d = S_DECODE;
            end else if (mem_timeout) begin
               wait_d  = '0;
               state_d = S_FAULT;
            end else begin
               wait_d  = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            ALUSrcA = 2'd2;
            ALUSrcB = 2'd2;
            case (InstType)
               T_R, T_I:         state_d = S_EXEC;
               T_LOAD, T_STORE:  state_d = S_MEMADDR;
               T_BR:             state_d = S_BRANCH;
               T_JAL, T_JALR:    state_d = S_JUMP;
               default:          state_d = S_FAULT;
            endcase
         end
         S_EXEC: begin
            ALUSrcA = 2'd1;
            ALUSrcB = (InstType == T_R) ? 2'd0 : 2'd2;
            // shifts use mod to pick logical vs arithmetic right shift
            if (InstType == T_R || funct3 == 3'b101) alu_op = {mod, funct3};
            else                                     alu_op = {2'b00, funct3};
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMADDR: begin
            ALUSrcA = 2'd1;
            ALUSrcB = 2'd2;
            if (InstType == T_LOAD)       state_d = S_MEMRD;
            else if (InstType == T_STORE) state_d = S_MEMWR;
            else                          state_d = S_FAULT;
         end
         S_MEMRD, S_MEMWR: begin
            IorD     = 1'b1;
            MemRead  = (state_q == S_MEMRD);
            MemWrite = (state_q == S_MEMWR);
            if (mem_ready) begin
               wait_d  = '0;
               state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
            end else if (mem_timeout) begin
               wait_d  = '0;
               state_d = S_FAULT;
            end else begin
               wait_d  = wait_q + 8'd1;
            end
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemToReg = 2'd1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA  = 2'd1;
            PCSource = 2'd1;
            alu_op   = 5'b01000;
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
               PCWrite = (funct3 == 3'b000) ? zero : ~zero;
               state_d = S_FETCH;
            end else begin
               state_d = S_FAULT;
            end
         end
         S_JUMP: begin
            RegWrite = 1'b1;
            MemToReg = 2'd2;
            PCWrite  = 1'b1;
            PCSource = (InstType == T_JALR) ? 2'd2 : 2'd1;
            ALUSrcA  = 2'd1;
            ALUSrcB  = 2'd2;
            state_d  = S_FETCH;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   assign ALUcontrol = ALU_CTRL_W'(alu_op);
   assign state      = state_q;
   assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Bench for riscv_multicycle_control: decode vector table, directed multi-cycle
// sequences, and randomized instructions checked against per-instruction totals.
module tb_riscv_multicycle_control;
   localparam int TMO = 3;
   localparam int ACW = 7;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   logic clk = 1'b0;
   logic reset, zero, mem_ready;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [1:0] mod;
   logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, fault;
   logic [1:0] ALUSrcA, ALUSrcB, PCSource, MemToReg;
   logic [ACW-1:0] ALUcontrol;
   logic [2:0] InstType;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   riscv_multicycle_control #(.MEM_TIMEOUT(TMO), .ALU_CTRL_W(ACW)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .mod(mod),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .MemToReg(MemToReg), .ALUcontrol(ALUcontrol),
      .InstType(InstType), .state(state), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [1:0] md;
      logic [2:0] typ;
      logic [3:0] nxt;
      logic [4:0] alu;
   } vec_t;

   vec_t tbl[14];
   logic [6:0] ops[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] md,
                         input logic z);
      opcode = op;
      funct3 = f3;
      mod    = md;
      zero   = z;
   endtask

   // Whole-instruction totals derived from the documented cycle counts.
   function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                 input int wf, input int wm, output int cyc, output int rw,
                                 output int pw, output int mr, output int mw, output int flt);
      cyc = wf + 1; mr = wf + 1; pw = 1; rw = 0; mw = 0; flt = 0;
      case (op)
         OP_R, OP_I:     begin cyc += 3; rw = 1; end
         OP_LOAD:        begin cyc += wm + 4; mr += wm + 1; rw = 1; end
         OP_STORE:       begin cyc += wm + 3; mw = wm + 1; end
         OP_BR: begin
            cyc += 2;
            if (f3 == 3'd0)      pw += (z ? 1 : 0);
            else if (f3 == 3'd1) pw += (z ? 0 : 1);
            else                 flt = 1;
         end
         OP_JAL, OP_JALR: begin cyc += 2; rw = 1; pw += 1; end
         default:         begin cyc += 1; flt = 1; end
      endcase
   endfunction

   initial begin
      int seq[5];
      int e_cyc, e_rw, e_pw, e_mr, e_mw, e_flt;
      int cyc, rw, pw, mr, mw, acc, waited, need, wf, wm;
      bit left, done;
      logic [6:0] op;
      logic [2:0] f3;

      tbl[0]  = '{OP_R,     3'b000, 2'b00, 3'b111, 4'd2,  5'b00000};
      tbl[1]  = '{OP_R,     3'b000, 2'b10, 3'b111, 4'd2,  5'b10000};
      tbl[2]  = '{OP_I,     3'b101, 2'b10, 3'b001, 4'd2,  5'b10101};
      tbl[3]  = '{OP_I,     3'b000, 2'b10, 3'b001, 4'd2,  5'b00000};
      tbl[4]  = '{OP_I,     3'b101, 2'b00, 3'b001, 4'd2,  5'b00101};
      tbl[5]  = '{OP_I,     3'b001, 2'b01, 3'b001, 4'd2,  5'b00001};
      tbl[6]  = '{OP_R,     3'b100, 2'b01, 3'b111, 4'd2,  5'b01100};
      tbl[7]  = '{OP_LOAD,  3'b010, 2'b00, 3'b010, 4'd4,  5'b00000};
      tbl[8]  = '{OP_STORE, 3'b010, 2'b00, 3'b011, 4'd4,  5'b00000};
      tbl[9]  = '{OP_BR,    3'b000, 2'b00, 3'b100, 4'd8,  5'b00000};
      tbl[10] = '{OP_JAL,   3'b000, 2'b00, 3'b101, 4'd9,  5'b00000};
      tbl[11] = '{OP_JALR,  3'b000, 2'b00, 3'b110, 4'd9,  5'b00000};
      tbl[12] = '{7'b0000000, 3'b000, 2'b00, 3'b000, 4'd15, 5'b00000};
      tbl[13] = '{7'b1111111, 3'b000, 2'b00, 3'b000, 4'd15, 5'b00000};
      ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, 7'b0000000, 7'b1110011};
      seq = '{0, 1, 2, 3, 0};

      reset = 1'b1; mem_ready = 1'b1;
      set_ir(OP_R, 3'b000, 2'b00, 1'b0);
      do_reset();

      // reset state
      check("reset_state", state, 0);
      check("reset_fault", fault, 0);
      check("fetch_memread", MemRead, 1);
      check("fetch_iord", IorD, 0);
      check("fetch_alusrcb", ALUSrcB, 1);

      // decode table
      foreach (tbl[i]) begin
         do_reset();
         set_ir(tbl[i].op, tbl[i].f3, tbl[i].md, 1'b0);
         mem_ready = 1'b1;
         #1;
         check($sformatf("insttype[%0d]", i), InstType, tbl[i].typ);
         tick();
         tick();
         check($sformatf("after_decode[%0d]", i), state, tbl[i].nxt);
         if (tbl[i].nxt == 4'd2)
            check($sformatf("aluctl[%0d]", i), ALUcontrol, tbl[i].alu);
      end

      // add: state walk, RegWrite only in ALUWB
      do_reset();
      set_ir(OP_R, 3'b000, 2'b00, 1'b0);
      mem_ready = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("add_state[%0d]", i), state, seq[i]);
         check($sformatf("add_regwrite[%0d]", i), RegWrite, (i == 3) ? 1 : 0);
         tick();
      end

      // lw with three wait cycles in MEMRD
      do_reset();
      set_ir(OP_LOAD, 3'b010, 2'b00, 1'b0);
      mem_ready = 1'b1;
      tick(); tick(); tick();
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         #1;
         check($sformatf("lw_memrd_state[%0d]", k), state, 5);
         check($sformatf("lw_memrd_rd_iord[%0d]", k), {MemRead, IorD}, 3);
         tick();
      end
      check("lw_memwb_state", state, 6);
      check("lw_memwb_memtoreg", MemToReg, 1);
      check("lw_memwb_regwrite", RegWrite, 1);
      tick();
      check("lw_total_8_back_to_fetch", state, 0);

      // branches
      do_reset();
      set_ir(OP_BR, 3'b000, 2'b00, 1'b1);
      tick(); tick();
      #1;
      check("beq_state", state, 8);
      check("beq_taken_pcwrite", PCWrite, 1);
      check("beq_pcsource", PCSource, 1);
      check("beq_alu_sub", ALUcontrol, 8);
      tick();
      check("beq_to_fetch", state, 0);
      set_ir(OP_BR, 3'b001, 2'b00, 1'b1);
      tick(); tick();
      #1;
      check("bne_not_taken_pcwrite", PCWrite, 0);
      tick();
      set_ir(OP_BR, 3'b100, 2'b00, 1'b1);
      tick(); tick();
      #1;
      check("blt_pcwrite", PCWrite, 0);
      tick();
      check("blt_fault_state", state, 15);
      check("blt_fault_flag", fault, 1);

      // jumps
      for (int j = 0; j < 2; j++) begin
         do_reset();
         set_ir((j == 0) ? OP_JAL : OP_JALR, 3'b000, 2'b00, 1'b0);
         tick(); tick();
         #1;
         check($sformatf("jump_state[%0d]", j), state, 9);
         check($sformatf("jump_pcsource[%0d]", j), PCSource, j + 1);
         check($sformatf("jump_memtoreg[%0d]", j), MemToReg, 2);
         check($sformatf("jump_wr[%0d]", j), {RegWrite, PCWrite}, 3);
      end

      // fetch timeout, then ready arriving exactly at the limit
      do_reset();
      set_ir(OP_R, 3'b000, 2'b00, 1'b0);
      mem_ready = 1'b0;
      for (int k = 0; k < TMO + 1; k++) begin
         #1;
         check($sformatf("tmo_wait_state[%0d]", k), state, 0);
         tick();
      end
      check("tmo_fault_state", state, 15);
      check("tmo_fault_flag", fault, 1);
      check("tmo_fault_memread", MemRead, 0);
      do_reset();
      for (int k = 0; k < TMO + 1; k++) begin
         mem_ready = (k == TMO);
         tick();
      end
      check("tmo_late_ready_state", state, 1);
      check("tmo_late_ready_fault", fault, 0);

      // reset mid-MEMWR and mid-FAULT
      do_reset();
      set_ir(OP_STORE, 3'b010, 2'b00, 1'b0);
      mem_ready = 1'b1;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      tick();
      check("memwr_hold_state", state, 7);
      check("memwr_memwrite", MemWrite, 1);
      reset = 1'b1;
      tick();
      check("reset_memwr_state", state, 0);
      check("reset_memwr_fault", fault, 0);
      reset = 1'b0;
      mem_ready = 1'b1;
      set_ir(7'b0000000, 3'b000, 2'b00, 1'b0);
      tick(); tick(); tick();
      check("illegal_sticky_state", state, 15);
      check("illegal_sticky_fault", fault, 1);
      reset = 1'b1;
      tick();
      check("reset_fault_state", state, 0);
      check("reset_fault_flag", fault, 0);
      reset = 1'b0;

      // randomized instructions against whole-instruction totals
      do_reset();
      for (int n = 0; n < 80; n++) begin
         op = ops[$urandom_range(0, 8)];
         f3 = (op == OP_BR) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         set_ir(op, f3, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         wf = $urandom_range(0, TMO);
         wm = $urandom_range(0, TMO);
         model(op, f3, zero, wf, wm, e_cyc, e_rw, e_pw, e_mr, e_mw, e_flt);
         cyc = 0; rw = 0; pw = 0; mr = 0; mw = 0; acc = 0; waited = 0;
         left = 1'b0; done = 1'b0;
         #1;
         for (int c = 0; c < 40 && !done; c++) begin
            if (MemRead || MemWrite) begin
               need = (acc == 0) ? wf : wm;
               if (waited >= need) begin
                  mem_ready = 1'b1; acc++; waited = 0;
               end else begin
                  mem_ready = 1'b0; waited++;
               end
            end else begin
               mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            rw += int'(RegWrite);
            pw += int'(PCWrite);
            mr += int'(MemRead);
            mw += int'(MemWrite);
            tick();
            if (state != 4'd0) left = 1'b1;
            if (state == 4'd15 || (left && state == 4'd0)) done = 1'b1;
         end
         check($sformatf("rnd[%0d] completed op=%b", n, op), int'(done), 1);
         check($sformatf("rnd[%0d] cycles op=%b", n, op), cyc, e_cyc);
         check($sformatf("rnd[%0d] regwrites", n), rw, e_rw);
         check($sformatf("rnd[%0d] pcwrites", n), pw, e_pw);
         check($sformatf("rnd[%0d] memread_cycles", n), mr, e_mr);
         check($sformatf("rnd[%0d] memwrite_cycles", n), mw, e_mw);
         check($sformatf("rnd[%0d] fault", n), fault, e_flt);
         if (fault || !done) begin
            mem_ready = 1'b1;
            do_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
